// File: rtl/uart_tx_peripheral.sv
// Memory-mapped UART transmitter: DATA/STATUS/DIVISOR window, TX FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (11-bit frames, STATUS bit8 = 1).
module uart_tx_peripheral #(
  parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0000_0100,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  input  logic [63:0] address,
  input  logic        read,
  input  logic        write,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  localparam logic ParEn = 1'b1;
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
  localparam logic ParEn = 1'b0;
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_t;
`endif

  state_t          r_state;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_count;
  logic            r_ovf, r_prev_acc;
  logic [63:0]     r_prev_addr;
  logic [15:0]     r_div, r_bit_div, r_cnt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  logic            r_tx, r_irq;
`ifdef UART_TX_PARITY_EN
  logic            r_parity;
`endif

  logic        w_sel_data, w_sel_stat, w_sel_div, w_match, w_acc, w_wr;
  logic        w_full, w_empty, w_busy, w_bit_end, w_pop, w_push_req, w_push;
  logic [15:0] w_div_next;
  logic [7:0]  w_head;
  logic [63:0] w_status, w_rd_val;
  logic        w_rd_en;
  logic        w_unused;

  assign w_sel_data = (address == BASE_ADDR);
  assign w_sel_stat = (address == BASE_ADDR + 64'd8);
  assign w_sel_div  = (address == BASE_ADDR + 64'd16);
  assign w_match    = w_sel_data | w_sel_stat | w_sel_div;
  assign w_acc      = write && w_match;
  // A held strobe on the same address acts once; moving to another address re-arms it.
  assign w_wr       = w_acc && !(r_prev_acc && (r_prev_addr == address));

  assign w_full     = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != StIdle);
  assign w_head     = r_mem[r_rptr];
  assign w_bit_end  = w_busy && (r_cnt == r_bit_div - 16'd1);
  // Popping on the stop bit's last edge starts the next frame with no idle gap.
  assign w_pop      = !w_empty && ((r_state == StIdle) || ((r_state == StStop) && w_bit_end));
  assign w_push_req = w_wr && w_sel_data;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_div_next = (w_wr && w_sel_div) ?
                      ((data[15:0] == 16'd0) ? 16'd1 : data[15:0]) : r_div;

  assign w_status = {55'd0, ParEn, 4'(r_count), r_ovf, w_empty, w_full, w_busy};
  assign w_rd_en  = read && !write && w_match;
  assign w_unused = ^data[63:16];

  always_comb begin
    w_rd_val = 64'd0;
    if (w_sel_stat) w_rd_val = w_status;
    if (w_sel_div)  w_rd_val = {48'd0, r_div};
  end

  assign data = w_rd_en ? w_rd_val : 64'bz;
  assign tx   = r_tx;
  assign irq  = r_irq;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div       <= DEFAULT_DIVISOR;
      r_ovf       <= 1'b0;
      r_prev_acc  <= 1'b0;
      r_prev_addr <= 64'd0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_prev_acc  <= w_acc;
      r_prev_addr <= address;
      r_div       <= w_div_next;
      if (w_push_req && !w_push)                r_ovf <= 1'b1;
      else if (w_wr && w_sel_stat && data[3])   r_ovf <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Bit length is latched at each bit boundary so a divisor write never stretches a bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_tx      <= 1'b1;
      r_irq     <= 1'b1;
      r_cnt     <= 16'd0;
      r_bit_div <= DEFAULT_DIVISOR;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_irq <= w_empty && (r_state == StIdle);
      if (w_busy)    r_cnt     <= w_bit_end ? 16'd0 : r_cnt + 16'd1;
      if (w_bit_end) r_bit_div <= w_div_next;
      if (w_pop) begin
        r_state   <= StStart;
        r_tx      <= 1'b0;
        r_cnt     <= 16'd0;
        r_bit_div <= w_div_next;
        r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
        r_parity  <= ^w_head;
`endif
      end else begin
        case (r_state)
          StIdle: r_tx <= 1'b1;
          StStart: begin
            if (w_bit_end) begin
              r_state   <= StData;
              r_bit_idx <= 3'd0;
              r_tx      <= r_shift[0];
            end
          end
          StData: begin
            if (w_bit_end) begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                r_state <= StParity;
                r_tx    <= r_parity;
`else
                r_state <= StStop;
                r_tx    <= 1'b1;
`endif
              end else begin
                r_tx <= r_shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          StParity: begin
            if (w_bit_end) begin
              r_state <= StStop;
              r_tx    <= 1'b1;
            end
          end
`endif
          StStop: begin
            if (w_bit_end) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end
endmodule
